// File: rtl/sargantana_icache_pkg.sv
// rtl/sargantana_icache_pkg.sv - shared types and helpers of the I-cache refill engine
package sargantana_icache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RECV  = 2'd2,
    WRITE = 2'd3
  } icache_refill_state_t;

  function automatic int calc_n_beats(input int line_w, input int beat_w);
    return line_w / beat_w;
  endfunction

endpackage

// File: rtl/sargantana_icache_victim_sel.sv
// rtl/sargantana_icache_victim_sel.sv - invalid-first victim choice plus replacement state
// SARGANTANA_ICACHE_PLRU_EN selects per-set tree PLRU; otherwise a global round-robin pointer.
module sargantana_icache_victim_sel #(
  parameter int N_WAY     = 4,
  parameter int IDX_WIDTH = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IDX_WIDTH-1:0] lookup_idx_i,
  input  logic [N_WAY-1:0]     valid_bits_i,
  output logic [N_WAY-1:0]     victim_o,
  input  logic                 fill_valid_i,
  input  logic [N_WAY-1:0]     fill_way_i,
  input  logic [IDX_WIDTH-1:0] fill_idx_i,
  input  logic                 hit_valid_i,
  input  logic [N_WAY-1:0]     hit_way_i,
  input  logic [IDX_WIDTH-1:0] hit_idx_i
);

  localparam int WAY_IDX_W = $clog2(N_WAY);

  logic             inv_found;
  logic [N_WAY-1:0] inv_way;
  logic [N_WAY-1:0] repl_way;

  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < N_WAY; w++) begin
      if (!valid_bits_i[w] && !inv_found) begin
        inv_found  = 1'b1;
        inv_way[w] = 1'b1;
      end
    end
  end

  assign victim_o = inv_found ? inv_way : repl_way;

`ifdef SARGANTANA_ICACHE_PLRU_EN
  typedef logic [N_WAY-2:0] tree_t;

  tree_t tree_q [2**IDX_WIDTH];
  tree_t tree_d [2**IDX_WIDTH];

  function automatic logic [WAY_IDX_W-1:0] oh2idx(input logic [N_WAY-1:0] oh);
    logic [WAY_IDX_W-1:0] idx;
    idx = '0;
    for (int w = 0; w < N_WAY; w++) begin
      if (oh[w]) idx = WAY_IDX_W'(w);
    end
    return idx;
  endfunction

  // Level l of the tree splits on way-index bit l (LSB first); a node bit
  // records which half was touched most recently.
  function automatic tree_t tree_update(input tree_t t, input logic [WAY_IDX_W-1:0] w);
    tree_t r;
    int    node;
    r    = t;
    node = 0;
    for (int l = 0; l < WAY_IDX_W; l++) begin
      for (int n = 0; n < N_WAY - 1; n++) begin
        if (n == node) r[n] = w[l];
      end
      node = 2 * node + 1 + (w[l] ? 1 : 0);
    end
    return r;
  endfunction

  function automatic logic [WAY_IDX_W-1:0] tree_victim(input tree_t t);
    logic [WAY_IDX_W-1:0] idx;
    logic                 b;
    int                   node;
    idx  = '0;
    node = 0;
    for (int l = 0; l < WAY_IDX_W; l++) begin
      b = 1'b0;
      for (int n = 0; n < N_WAY - 1; n++) begin
        if (n == node) b = t[n];
      end
      idx[l] = !b;
      node   = 2 * node + 1 + (b ? 0 : 1);
    end
    return idx;
  endfunction

  // Fill update is applied last so it overrides a same-set hit update.
  always_comb begin
    tree_d = tree_q;
    if (hit_valid_i) tree_d[hit_idx_i] = tree_update(tree_q[hit_idx_i], oh2idx(hit_way_i));
    if (fill_valid_i) tree_d[fill_idx_i] = tree_update(tree_q[fill_idx_i], oh2idx(fill_way_i));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < 2**IDX_WIDTH; s++) tree_q[s] <= '0;
    end else begin
      tree_q <= tree_d;
    end
  end

  assign repl_way = N_WAY'(1) << tree_victim(tree_q[lookup_idx_i]);
`else
  logic [WAY_IDX_W-1:0] rr_q, rr_d;
  logic                 unused_hit;

  always_comb begin
    rr_d = rr_q;
    if (fill_valid_i && !inv_found) rr_d = rr_q + WAY_IDX_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rr_q <= '0;
    else       rr_q <= rr_d;
  end

  assign repl_way   = N_WAY'(1) << rr_q;
  assign unused_hit = ^{hit_valid_i, hit_way_i, hit_idx_i, fill_way_i, fill_idx_i, lookup_idx_i};
`endif

endmodule

// File: rtl/sargantana_icache_refill.sv
// rtl/sargantana_icache_refill.sv - I-cache miss fill engine: L2 request, beat assembly, way write
// Replacement policy chosen by SARGANTANA_ICACHE_PLRU_EN (tree PLRU) else round-robin.
module sargantana_icache_refill
  import sargantana_icache_pkg::*;
#(
  parameter int ICACHE_N_WAY = 4,
  parameter int TAG_WIDHT    = 20,
  parameter int IDX_WIDTH    = 6,
  parameter int WAY_WIDHT    = 512,
  parameter int BEAT_WIDTH   = 128
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           miss_valid_i,
  output logic                           miss_ready_o,
  input  logic [TAG_WIDHT-1:0]           miss_tag_i,
  input  logic [IDX_WIDTH-1:0]           miss_idx_i,
  input  logic [ICACHE_N_WAY-1:0]        way_valid_bits_i,
  input  logic                           flush_i,
  output logic                           l2_req_valid_o,
  input  logic                           l2_req_ready_i,
  output logic [TAG_WIDHT+IDX_WIDTH-1:0] l2_req_addr_o,
  input  logic                           l2_resp_valid_i,
  output logic                           l2_resp_ready_o,
  input  logic [BEAT_WIDTH-1:0]          l2_resp_data_i,
  input  logic                           l2_resp_last_i,
  input  logic                           l2_resp_error_i,
  output logic                           wr_en_o,
  output logic [ICACHE_N_WAY-1:0]        wr_way_o,
  output logic [IDX_WIDTH-1:0]           wr_idx_o,
  output logic [TAG_WIDHT-1:0]           wr_tag_o,
  output logic [WAY_WIDHT-1:0]           wr_data_o,
  output logic [WAY_WIDHT-1:0]           ifill_data_o,
  output logic                           ifill_valid_o,
  output logic                           fill_error_o,
  input  logic                           hit_valid_i,
  input  logic [ICACHE_N_WAY-1:0]        hit_way_i,
  input  logic [IDX_WIDTH-1:0]           hit_idx_i
);

  localparam int N_BEATS = calc_n_beats(WAY_WIDHT, BEAT_WIDTH);
  // One extra count value marks "line full, dropping beats until last".
  localparam int CNT_W = $clog2(N_BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);

  icache_refill_state_t          state_q, state_d;
  logic [TAG_WIDHT-1:0]          tag_q, tag_d;
  logic [IDX_WIDTH-1:0]          idx_q, idx_d;
  logic [ICACHE_N_WAY-1:0]       vbits_q, vbits_d;
  logic [ICACHE_N_WAY-1:0]       way_q, way_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [WAY_WIDHT-1:0]          line_q, line_d;
  logic                          kill_q, kill_d;
  logic                          err_q, err_d;
  logic                          fill_err_q, fill_err_d;
  logic [ICACHE_N_WAY-1:0]       victim_way;

  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    idx_d      = idx_q;
    vbits_d    = vbits_q;
    way_d      = way_q;
    cnt_d      = cnt_q;
    line_d     = line_q;
    kill_d     = kill_q;
    err_d      = err_q;
    fill_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (miss_valid_i) begin
          tag_d   = miss_tag_i;
          idx_d   = miss_idx_i;
          vbits_d = way_valid_bits_i;
          kill_d  = 1'b0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (flush_i) kill_d = 1'b1;
        if (l2_req_ready_i) state_d = RECV;
      end
      RECV: begin
        if (flush_i) kill_d = 1'b1;
        if (l2_resp_valid_i) begin
          if (cnt_q <= LAST_BEAT) begin
            for (int b = 0; b < N_BEATS; b++) begin
              if (cnt_q == CNT_W'(b)) line_d[b*BEAT_WIDTH +: BEAT_WIDTH] = l2_resp_data_i;
            end
            cnt_d = cnt_q + CNT_W'(1);
          end
          // last must coincide exactly with the final beat slot
          if (l2_resp_error_i || (l2_resp_last_i != (cnt_q == LAST_BEAT))) err_d = 1'b1;
          if (l2_resp_last_i) begin
            if (!err_d && !kill_d) begin
              way_d   = victim_way;
              state_d = WRITE;
            end else begin
              fill_err_d = err_d;
              state_d    = IDLE;
            end
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      tag_q      <= '0;
      idx_q      <= '0;
      vbits_q    <= '0;
      way_q      <= '0;
      cnt_q      <= '0;
      line_q     <= '0;
      kill_q     <= 1'b0;
      err_q      <= 1'b0;
      fill_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      idx_q      <= idx_d;
      vbits_q    <= vbits_d;
      way_q      <= way_d;
      cnt_q      <= cnt_d;
      line_q     <= line_d;
      kill_q     <= kill_d;
      err_q      <= err_d;
      fill_err_q <= fill_err_d;
    end
  end

  sargantana_icache_victim_sel #(
    .N_WAY     (ICACHE_N_WAY),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_victim_sel (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .lookup_idx_i (idx_q),
    .valid_bits_i (vbits_q),
    .victim_o     (victim_way),
    .fill_valid_i (wr_en_o),
    .fill_way_i   (way_q),
    .fill_idx_i   (idx_q),
    .hit_valid_i  (hit_valid_i),
    .hit_way_i    (hit_way_i),
    .hit_idx_i    (hit_idx_i)
  );

  assign miss_ready_o    = (state_q == IDLE);
  assign l2_req_valid_o  = (state_q == REQ);
  assign l2_req_addr_o   = {tag_q, idx_q};
  assign l2_resp_ready_o = (state_q == RECV);
  assign wr_en_o         = (state_q == WRITE);
  assign ifill_valid_o   = wr_en_o;
  assign wr_way_o        = way_q;
  assign wr_idx_o        = idx_q;
  assign wr_tag_o        = tag_q;
  assign wr_data_o       = line_q;
  assign ifill_data_o    = line_q;
  assign fill_error_o    = fill_err_q;

endmodule

// File: doc/sargantana_icache_refill.md
# sargantana_icache_refill

Miss-side fill engine of the Sargantana instruction cache. It accepts a miss (tag, set index, valid bits of the addressed set), requests the line from L2, and assembles the multi-beat response. It then chooses a victim way and issues a single-cycle write of tag, data and valid bit into the way arrays. It also forwards the assembled line as `ifill_data_o`, the line the hit/select path uses to serve the pending fetch.

## Interface
Parameters:
- `ICACHE_N_WAY`, 4: ways per set (power of 2, ≥2)
- `TAG_WIDHT`, 20: tag width
- `IDX_WIDTH`, 6: set index width
- `WAY_WIDHT`, 512: line width in bits
- `BEAT_WIDTH`, 128: L2 response beat width; `N_BEATS = WAY_WIDHT/BEAT_WIDTH`, which must be an integer ≥1

Ports:
- `clk_i`  in  1  clock; all logic on rising edge
- `rst_i`  in  1  synchronous, active-high reset
- `miss_valid_i`  in  1  miss request
- `miss_ready_o`  out  1  high only in IDLE
- `miss_tag_i`  in  TAG_WIDHT  missing tag
- `miss_idx_i`  in  IDX_WIDTH  missing set
- `way_valid_bits_i`  in  ICACHE_N_WAY  valid bits of `miss_idx_i`, sampled at miss accept
- `flush_i`  in  1  kill the in-flight fill
- `l2_req_valid_o`  out  1  L2 request
- `l2_req_ready_i`  in  1  L2 accepts request
- `l2_req_addr_o`  out  TAG_WIDHT+IDX_WIDTH  `{tag, idx}` of line
- `l2_resp_valid_i`  in  1  response beat valid
- `l2_resp_ready_o`  out  1  high only in RECV
- `l2_resp_data_i`  in  BEAT_WIDTH  beat payload
- `l2_resp_last_i`  in  1  final beat
- `l2_resp_error_i`  in  1  beat carries bus error
- `wr_en_o`  out  1  array write strobe
- `wr_way_o`  out  ICACHE_N_WAY  one-hot victim
- `wr_idx_o`  out  IDX_WIDTH  set written
- `wr_tag_o`  out  TAG_WIDHT  tag written
- `wr_data_o` / `ifill_data_o`  out  WAY_WIDHT  assembled line; both ports carry the same signal
- `ifill_valid_o`  out  1  equals `wr_en_o`
- `fill_error_o`  out  1  one-cycle pulse; fill aborted
- `hit_valid_i`  in  1  lookup hit (used for replacement update)
- `hit_way_i`  in  ICACHE_N_WAY  one-hot hit way
- `hit_idx_i`  in  IDX_WIDTH  hit set

## Operation
- FSM states: IDLE, REQ, RECV, WRITE.
  - IDLE→REQ on `miss_valid_i & miss_ready_o`. Latch tag, idx and valid bits; clear the kill flag, error flag and beat counter.
  - REQ holds `l2_req_valid_o`=1 with stable `l2_req_addr_o`. REQ→RECV on `l2_req_ready_i`.
  - RECV: each `l2_resp_valid_i` writes beat k into line bits `[k*BEAT_WIDTH +: BEAT_WIDTH]`, then increments k.
    - The error flag is set if `l2_resp_error_i` is high on any beat, or `l2_resp_last_i` arrives at k≠N_BEATS-1.
    - A beat at k=N_BEATS-1 without `last` also sets the error flag; further beats are dropped until `last`.
    - On a beat with `last`: go to WRITE if neither the error flag nor the kill flag is set (including error this beat). Otherwise go to IDLE; pulse `fill_error_o` only if the error flag is set.
  - WRITE lasts one cycle, `wr_en_o`=`ifill_valid_o`=1, then →IDLE.
- Victim selection: lowest-index way whose latched valid bit is 0. If all ways are valid, the replacement policy (see Configuration) picks the victim.
- `flush_i` in REQ/RECV sets the kill flag. The L2 transaction still completes through `last`, but no write occurs. `flush_i` in IDLE or WRITE has no effect.
- Reset: state IDLE; all outputs 0 except `miss_ready_o`=1; line register, counters and replacement state cleared.

## Timing
- Miss accepted at cycle T → `l2_req_valid_o` at T+1.
- With `l2_req_ready_i` at T+1 and back-to-back beats, the beats arrive T+2..T+1+N_BEATS and `wr_en_o` is high at T+2+N_BEATS. For the defaults that is T+6.
- Minimum miss-to-miss spacing is N_BEATS+3 cycles; `miss_ready_o` returns to 1 the cycle after WRITE.
- `wr_*` and `ifill_data_o` are registered and stable during WRITE.
- Replacement state updates on the clock edge ending WRITE.
- If a hit update and a fill update target the same set in the same cycle, the fill update wins.

## Configuration
- `SARGANTANA_ICACHE_PLRU_EN` defined: tree pseudo-LRU, ICACHE_N_WAY-1 bits per set.
  - Bits are updated toward the accessed way on every `hit_valid_i` and on every WRITE.
  - The victim is the way the tree points away from.
- Not defined: one global round-robin pointer, advanced only when a WRITE uses it (all ways valid).
  - `hit_*` inputs are ignored.

## Structure
- `sargantana_icache_pkg`: `icache_refill_state_t` enum and the `N_BEATS` derivation helper.
- Sub-module `sargantana_icache_victim_sel` implements invalid-first plus RR/PLRU selection and holds the replacement state.

## Test plan
- Default params, miss tag 0x12345 idx 5 with valid 4'b0101, beats 0xA..0xD → `wr_way_o`=4'b0010; `wr_data_o` holds beat k at bits `[128k+127:128k]`; `wr_en_o` at T+6.
- All-valid misses, 5 sequential misses, round-robin build → `wr_way_o` sequence 0001, 0010, 0100, 1000, 0001.
- PLRU build, hits on ways 0, 1, 2 in set 3, then an all-valid miss to set 3 → victim 4'b1000.
- `l2_resp_error_i` on beat 2 → no `wr_en_o`; `fill_error_o` pulses once after `last`; back in IDLE.
- `last` on beat 1 of 4 → `fill_error_o` pulse, no write.
- `flush_i` during RECV → remaining beats consumed, no write, no `fill_error_o`; `rst_i` mid-RECV → IDLE and all outputs 0 next cycle.
